// File: rtl/victim_sel_nway_if.sv
// rtl/victim_sel_nway_if.sv - lookup request/response bundle between cache controller and victim selector
interface victim_sel_nway_if #(
    parameter int WAYS  = 4,
    parameter int IDX_W = 6,
    parameter int WAY_W = 2
);
    logic              req_valid;
    logic [IDX_W-1:0]  req_idx;
    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_dirty;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              resp_valid;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_dirty;

    modport master (
        output req_valid, req_idx, way_valid, way_dirty, hit, hit_way,
        input  resp_valid, victim_way, victim_dirty
    );

    modport slave (
        input  req_valid, req_idx, way_valid, way_dirty, hit, hit_way,
        output resp_valid, victim_way, victim_dirty
    );
endinterface

// File: rtl/victim_sel_nway.sv
// rtl/victim_sel_nway.sv - N-way victim selector with per-set tree-PLRU or round-robin state
module victim_sel_nway #(
    parameter int WAYS         = 4,
    parameter int SETS         = 64,
    parameter int IDX_W        = 6,
    parameter int WAY_W        = 2,
    parameter int MODE         = 0,
    parameter int PREFER_CLEAN = 1
) (
    input  logic               clk,
    input  logic               rst,
    victim_sel_nway_if.slave   bus
);

    // Follow the heap-ordered tree from the root; the chosen directions,
    // MSB first, spell out the leaf (way) index.
    function automatic logic [WAY_W-1:0] plru_walk(input logic [WAYS-1:1] bits);
        logic [WAY_W-1:0] way;
        logic             dir;
        int               node;
        way  = '0;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            dir                = bits[WAY_W'(node)];
            way[WAY_W-1-l]     = dir;
            node               = node * 2 + int'(dir);
        end
        return way;
    endfunction

    // Make every node on the path to w point into the opposite subtree.
    function automatic logic [WAYS-1:1] plru_touch(input logic [WAYS-1:1] bits,
                                                   input logic [WAY_W-1:0] w);
        logic [WAYS-1:1] nb;
        logic            dir;
        int              node;
        nb   = bits;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            dir                = w[WAY_W-1-l];
            nb[WAY_W'(node)]   = ~dir;
            node               = node * 2 + int'(dir);
        end
        return nb;
    endfunction

    logic [WAY_W-1:0] policy_cand;
    logic [WAY_W-1:0] victim_d;
    logic             victim_dirty_d;
    logic [WAY_W-1:0] miss_way;
    logic [WAY_W-1:0] touch_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic             clean_found;
    logic [WAY_W-1:0] clean_way;
    logic [WAYS-1:0]  clean_vec;

    logic             resp_valid_q;
    logic [WAY_W-1:0] victim_way_q;
    logic             victim_dirty_q;

    // Victim priority: invalid way first, then (optionally) a clean way, then policy candidate.
    always_comb begin
        inv_found      = 1'b0;
        inv_way        = '0;
        clean_found    = 1'b0;
        clean_way      = '0;
        clean_vec      = bus.way_valid & ~bus.way_dirty;
        miss_way       = policy_cand;
        victim_d       = '0;
        victim_dirty_d = 1'b0;

        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.way_valid[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
            if (clean_vec[i]) begin
                clean_found = 1'b1;
                clean_way   = WAY_W'(i);
            end
        end

        if (inv_found) begin
            miss_way = inv_way;
        end else if ((PREFER_CLEAN != 0) && clean_found) begin
            miss_way = clean_vec[policy_cand] ? policy_cand : clean_way;
        end

        if (bus.hit) begin
            victim_d       = bus.hit_way;
            victim_dirty_d = 1'b0;
        end else begin
            victim_d       = miss_way;
            victim_dirty_d = bus.way_valid[miss_way] & bus.way_dirty[miss_way];
        end

        touch_way = victim_d;
    end

    generate
        if (MODE == 0) begin : g_plru
            logic [WAYS-1:1] plru_q [SETS];

            assign policy_cand = plru_walk(plru_q[bus.req_idx]);

            // Per-set PLRU tree: cleared on reset, touched by the hit or chosen victim.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        plru_q[s] <= '0;
                    end
                end else if (bus.req_valid) begin
                    plru_q[bus.req_idx] <= plru_touch(plru_q[bus.req_idx], touch_way);
                end
            end
        end else begin : g_rr
            logic [WAY_W-1:0] rr_q [SETS];

            assign policy_cand = rr_q[bus.req_idx];

            // Per-set round-robin pointer: advances past the victim on misses only.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        rr_q[s] <= '0;
                    end
                end else if (bus.req_valid && !bus.hit) begin
                    rr_q[bus.req_idx] <= victim_d + 1'b1;
                end
            end
        end
    endgenerate

    // Response register: one-cycle pulse per request; way/dirty hold between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q   <= 1'b0;
            victim_way_q   <= '0;
            victim_dirty_q <= 1'b0;
        end else begin
            resp_valid_q <= bus.req_valid;
            if (bus.req_valid) begin
                victim_way_q   <= victim_d;
                victim_dirty_q <= victim_dirty_d;
            end
        end
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.victim_way   = victim_way_q;
    assign bus.victim_dirty = victim_dirty_q;

endmodule

// File: tb/tb_victim_sel_nway.sv
// tb/tb_victim_sel_nway.sv - bench for victim_sel_nway (PLRU, round-robin, no-prefer-clean variants)
module tb_victim_sel_nway;
    localparam int WAYS  = 4;
    localparam int SETS  = 64;
    localparam int IDX_W = 6;
    localparam int WAY_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst       = 1'b1;
    logic             req_valid = 1'b0;
    logic [IDX_W-1:0] req_idx   = '0;
    logic [WAYS-1:0]  way_valid = '0;
    logic [WAYS-1:0]  way_dirty = '0;
    logic             hit       = 1'b0;
    logic [WAY_W-1:0] hit_way   = '0;

    victim_sel_nway_if #(.WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) bus0 ();
    victim_sel_nway_if #(.WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) bus1 ();
    victim_sel_nway_if #(.WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) bus2 ();

    assign bus0.req_valid = req_valid; assign bus0.req_idx = req_idx;
    assign bus0.way_valid = way_valid; assign bus0.way_dirty = way_dirty;
    assign bus0.hit = hit;             assign bus0.hit_way = hit_way;
    assign bus1.req_valid = req_valid; assign bus1.req_idx = req_idx;
    assign bus1.way_valid = way_valid; assign bus1.way_dirty = way_dirty;
    assign bus1.hit = hit;             assign bus1.hit_way = hit_way;
    assign bus2.req_valid = req_valid; assign bus2.req_idx = req_idx;
    assign bus2.way_valid = way_valid; assign bus2.way_dirty = way_dirty;
    assign bus2.hit = hit;             assign bus2.hit_way = hit_way;

    // dut0: PLRU + prefer clean, dut1: round-robin + prefer clean, dut2: PLRU, no prefer clean
    victim_sel_nway #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .WAY_W(WAY_W), .MODE(0), .PREFER_CLEAN(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    victim_sel_nway #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .WAY_W(WAY_W), .MODE(1), .PREFER_CLEAN(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    victim_sel_nway #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .WAY_W(WAY_W), .MODE(0), .PREFER_CLEAN(0))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic             rv_o [3];
    logic [WAY_W-1:0] way_o [3];
    logic             d_o [3];
    assign rv_o[0] = bus0.resp_valid; assign way_o[0] = bus0.victim_way; assign d_o[0] = bus0.victim_dirty;
    assign rv_o[1] = bus1.resp_valid; assign way_o[1] = bus1.victim_way; assign d_o[1] = bus1.victim_dirty;
    assign rv_o[2] = bus2.resp_valid; assign way_o[2] = bus2.victim_way; assign d_o[2] = bus2.victim_dirty;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    task automatic cycle(input logic r, input logic rv, input int idx, input logic [3:0] v,
                         input logic [3:0] d, input logic h, input int hw);
        @(negedge clk);
        rst       = r;
        req_valid = rv;
        req_idx   = IDX_W'(idx);
        way_valid = v;
        way_dirty = d;
        hit       = h;
        hit_way   = WAY_W'(hw);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r;
        logic       rv;
        int         idx;
        logic [3:0] v;
        logic [3:0] d;
        logic       h;
        int         hw;
        logic [2:0] chk;
        logic       erv;
        int         ew0;
        int         ew1;
        int         ew2;
        logic [2:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rv, input int idx, input logic [3:0] v,
                                input logic [3:0] d, input logic h, input int hw, input logic [2:0] chk,
                                input logic erv, input int ew0, input int ew1, input int ew2,
                                input logic [2:0] ed);
        vec_t t;
        t.r = r; t.rv = rv; t.idx = idx; t.v = v; t.d = d; t.h = h; t.hw = hw;
        t.chk = chk; t.erv = erv; t.ew0 = ew0; t.ew1 = ew1; t.ew2 = ew2; t.ed = ed;
        return t;
    endfunction

    // reference model: tree as node array walked by interval halving, RR as integer pointer
    int tree  [3][SETS][WAYS];
    int ptr   [3][SETS];
    int e_rv  [3];
    int e_way [3];
    int e_d   [3];
    int mode_of [3] = '{0, 1, 0};
    int pc_of   [3] = '{1, 1, 0};

    function automatic int plru_cand(input int m, input int s);
        int node = 1, lo = 0, size = WAYS;
        while (size > 1) begin
            size = size / 2;
            if (tree[m][s][node] != 0) begin lo += size; node = 2 * node + 1; end
            else node = 2 * node;
        end
        return lo;
    endfunction

    task automatic plru_touch_m(input int m, input int s, input int w);
        int node = 1, lo = 0, size = WAYS;
        while (size > 1) begin
            size = size / 2;
            if (w < lo + size) begin tree[m][s][node] = 1; node = 2 * node; end
            else begin tree[m][s][node] = 0; lo += size; node = 2 * node + 1; end
        end
    endtask

    task automatic model_step(input int m, input bit r, input bit rv, input int idx,
                              input bit [3:0] v, input bit [3:0] d, input bit h, input int hw);
        int cand, vic;
        if (r) begin
            for (int s = 0; s < SETS; s++) begin
                ptr[m][s] = 0;
                for (int n = 0; n < WAYS; n++) tree[m][s][n] = 0;
            end
            e_rv[m] = 0; e_way[m] = 0; e_d[m] = 0;
            return;
        end
        e_rv[m] = rv ? 1 : 0;
        if (!rv) return;
        if (h) begin
            e_way[m] = hw; e_d[m] = 0;
            if (mode_of[m] == 0) plru_touch_m(m, idx, hw);
            return;
        end
        cand = (mode_of[m] == 0) ? plru_cand(m, idx) : ptr[m][idx];
        vic = -1;
        for (int i = 0; i < WAYS; i++) if (!v[i] && vic < 0) vic = i;
        if (vic < 0) begin
            if (pc_of[m] != 0 && d != 4'hf) begin
                if (!d[cand]) vic = cand;
                else for (int i = 0; i < WAYS; i++) if (!d[i] && vic < 0) vic = i;
            end else begin
                vic = cand;
            end
        end
        e_way[m] = vic;
        e_d[m]   = (v[vic] && d[vic]) ? 1 : 0;
        if (mode_of[m] == 0) plru_touch_m(m, idx, vic);
        else ptr[m][idx] = (vic + 1) % WAYS;
    endtask

    vec_t tbl [$];

    initial begin
        // directed table: each row is one cycle; expectations are the registered response of that row
        tbl.push_back(mk(1,0, 0,4'b0000,4'b0000,0,0,3'b111,0, 0,0,0,3'b000)); // reset
        tbl.push_back(mk(0,1, 3,4'b0000,4'b0000,0,0,3'b111,1, 0,0,0,3'b000)); // all invalid
        tbl.push_back(mk(0,1, 3,4'b1011,4'b0000,0,0,3'b111,1, 2,2,2,3'b000)); // way 2 invalid
        tbl.push_back(mk(0,0, 3,4'b1011,4'b0000,0,0,3'b111,0, 2,2,2,3'b000)); // idle: hold
        tbl.push_back(mk(0,1, 0,4'b1111,4'b0000,0,0,3'b111,1, 0,0,0,3'b000)); // set 0 misses
        tbl.push_back(mk(0,1, 0,4'b1111,4'b0000,0,0,3'b111,1, 2,1,2,3'b000));
        tbl.push_back(mk(0,1, 0,4'b1111,4'b0000,0,0,3'b111,1, 1,2,1,3'b000));
        tbl.push_back(mk(0,1, 0,4'b1111,4'b0000,0,0,3'b111,1, 3,3,3,3'b000));
        tbl.push_back(mk(0,1, 0,4'b1111,4'b0000,0,0,3'b111,1, 0,0,0,3'b000));
        tbl.push_back(mk(0,1, 5,4'b1111,4'b0000,1,0,3'b111,1, 0,0,0,3'b000)); // hit way 0 set 5
        tbl.push_back(mk(0,1, 6,4'b1111,4'b0000,0,0,3'b111,1, 0,0,0,3'b000)); // other set
        tbl.push_back(mk(0,1, 5,4'b1111,4'b0000,0,0,3'b111,1, 2,0,2,3'b000)); // miss set 5
        tbl.push_back(mk(0,1,10,4'b1111,4'b0001,0,0,3'b111,1, 1,1,0,3'b100)); // prefer clean
        tbl.push_back(mk(0,1,11,4'b1111,4'b1111,0,0,3'b111,1, 0,0,0,3'b111)); // all dirty
        tbl.push_back(mk(0,1, 2,4'b1111,4'b0000,0,0,3'b010,1, 0,0,0,3'b000)); // RR set 2
        tbl.push_back(mk(0,1, 2,4'b1111,4'b0000,0,0,3'b010,1, 0,1,0,3'b000));
        tbl.push_back(mk(0,1, 2,4'b1111,4'b0000,1,3,3'b111,1, 3,3,3,3'b000)); // hit mid-sequence
        tbl.push_back(mk(0,1, 2,4'b1111,4'b0000,0,0,3'b010,1, 0,2,0,3'b000));
        tbl.push_back(mk(0,1, 2,4'b1111,4'b0000,0,0,3'b010,1, 0,3,0,3'b000));
        tbl.push_back(mk(0,1, 2,4'b1111,4'b0000,0,0,3'b010,1, 0,0,0,3'b000));
        tbl.push_back(mk(1,1, 0,4'b1111,4'b0000,0,0,3'b111,0, 0,0,0,3'b000)); // rst beats request
        tbl.push_back(mk(0,1, 0,4'b1111,4'b0000,0,0,3'b111,1, 0,0,0,3'b000)); // victim 0
        tbl.push_back(mk(1,0, 0,4'b1111,4'b0000,0,0,3'b111,0, 0,0,0,3'b000)); // suppress pending
        tbl.push_back(mk(0,1, 0,4'b1111,4'b0000,0,0,3'b111,1, 0,0,0,3'b000)); // cleared again

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].r, tbl[k].rv, tbl[k].idx, tbl[k].v, tbl[k].d, tbl[k].h, tbl[k].hw);
            for (int i = 0; i < 3; i++) begin
                if (tbl[k].chk[i]) begin
                    check($sformatf("tbl[%0d] dut%0d resp_valid", k, i), int'(rv_o[i]), int'(tbl[k].erv));
                    check($sformatf("tbl[%0d] dut%0d victim_way", k, i), int'(way_o[i]),
                          (i == 0) ? tbl[k].ew0 : (i == 1) ? tbl[k].ew1 : tbl[k].ew2);
                    check($sformatf("tbl[%0d] dut%0d victim_dirty", k, i), int'(d_o[i]), int'(tbl[k].ed[i]));
                end
            end
        end

        // randomized phase against the reference model
        cycle(1, 0, 0, 4'hf, 4'h0, 0, 0);
        for (int m = 0; m < 3; m++) model_step(m, 1, 0, 0, 4'hf, 4'h0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            bit         r, rv, h;
            int         idx, hw;
            bit [3:0]   v, d;
            r   = ($urandom_range(0, 59) == 0);
            rv  = ($urandom_range(0, 4) != 0);
            idx = $urandom_range(0, 3);
            v   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
            d   = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom);
            h   = ($urandom_range(0, 3) == 0);
            hw  = $urandom_range(0, WAYS - 1);
            cycle(r, rv, idx, v, d, h, hw);
            for (int m = 0; m < 3; m++) begin
                model_step(m, r, rv, idx, v, d, h, hw);
                check($sformatf("rnd[%0d] dut%0d resp_valid", c, m), int'(rv_o[m]), e_rv[m]);
                check($sformatf("rnd[%0d] dut%0d victim_way", c, m), int'(way_o[m]), e_way[m]);
                check($sformatf("rnd[%0d] dut%0d victim_dirty", c, m), int'(d_o[m]), e_d[m]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
